// File: rtl/dct_pkg.sv
// Package for the DCT output zigzag buffer.
// Holds the default coefficient width, the coefficient and column types,
// and the zigzag-position to (row, col) lookup tables in standard JPEG order.
package dct_pkg;

  localparam int ZZ_DATA_W = 12;

  typedef logic signed [ZZ_DATA_W-1:0] coef_t;
  typedef coef_t [7:0]                 col_t;

  // Row of the coefficient emitted at zigzag position p (raster = 8*row + col).
  localparam int ZZ_ROW [64] = '{
    0, 0, 1, 2, 1, 0, 0, 1, 2, 3, 4, 3, 2, 1, 0, 0,
    1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 0, 1, 2, 3,
    4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 2, 3, 4, 5, 6,
    7, 7, 6, 5, 4, 3, 4, 5, 6, 7, 7, 6, 5, 6, 7, 7
  };

  // Column of the coefficient emitted at zigzag position p.
  localparam int ZZ_COL [64] = '{
    0, 1, 0, 0, 1, 2, 3, 2, 1, 0, 0, 1, 2, 3, 4, 5,
    4, 3, 2, 1, 0, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4,
    3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3,
    2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 5, 6, 7, 7, 6, 7
  };

endpackage

// File: rtl/dct_zigzag_bank.sv
// One 8x8 coefficient bank of the zigzag reorder buffer.
// Written a whole column at a time, read one element at a time through an
// (row, col) mux. Contents are storage only and are never reset.
// Ports:
//   clk      clock
//   wr_en    write column wr_col with wr_data this cycle
//   wr_col   column index 0..7
//   wr_data  8 coefficients, wr_data[r] lands in row r
//   rd_row   read row 0..7
//   rd_col   read column 0..7
//   rd_data  coefficient at (rd_row, rd_col), combinational
module dct_zigzag_bank
  import dct_pkg::*;
#(
  parameter int DATA_W = ZZ_DATA_W
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [2:0]                      wr_col,
  input  logic signed [7:0][DATA_W-1:0]   wr_data,
  input  logic [2:0]                      rd_row,
  input  logic [2:0]                      rd_col,
  output logic signed [DATA_W-1:0]        rd_data
);

  logic signed [DATA_W-1:0] mem [8][8];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int r = 0; r < 8; r++) begin
        mem[r][wr_col] <= wr_data[r];
      end
    end
  end

  assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/dct_zigzag_buf.sv
// Zigzag reorder buffer at the tail of the 2-D DCT pipeline.
// Takes an 8x8 block as 8 column beats and emits its 64 coefficients one per
// beat in JPEG zigzag order. Two banks ping-pong so block n+1 can fill while
// block n drains.
// Optional feature: define DCT_ZZ_STATS_EN to add the blk_cnt / stall_cnt
// statistics outputs; with it undefined those ports do not exist.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   column beat valid
//   in_ready   buffer can take a beat (from registered flags only)
//   in_data    beat k: in_data[r] = coefficient (row r, col k)
//   out_valid  out_data valid
//   out_ready  consumer takes out_data
//   out_data   coefficient at zigzag position out_idx (0 when not valid)
//   out_idx    zigzag position 0..63
//   out_last   high with out_idx == 63
//   blk_cnt    (stats) blocks fully emitted, wraps at 2^16
//   stall_cnt  (stats) cycles with in_valid && !in_ready, wraps at 2^16
module dct_zigzag_buf
  import dct_pkg::*;
#(
  parameter int DATA_W = ZZ_DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [7:0][DATA_W-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [DATA_W-1:0]        out_data,
  output logic [5:0]                      out_idx,
  output logic                            out_last
`ifdef DCT_ZZ_STATS_EN
  ,
  output logic [15:0]                     blk_cnt,
  output logic [15:0]                     stall_cnt
`endif
);

  logic [1:0]               full;
  logic                     wr_bank;
  logic [2:0]               wr_col;
  logic                     rd_bank;
  logic [5:0]               rd_pos;

  logic                     in_fire;
  logic                     out_fire;
  logic [1:0]               wr_en;
  logic [2:0]               rd_row;
  logic [2:0]               rd_col;
  logic signed [DATA_W-1:0] rd_data [2];

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign rd_row = 3'(ZZ_ROW[rd_pos]);
  assign rd_col = 3'(ZZ_COL[rd_pos]);

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_bank
      assign wr_en[b] = in_fire && (wr_bank == 1'(b));

      dct_zigzag_bank #(
        .DATA_W (DATA_W)
      ) u_bank (
        .clk     (clk),
        .wr_en   (wr_en[b]),
        .wr_col  (wr_col),
        .wr_data (in_data),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_data (rd_data[b])
      );
    end
  endgenerate

  // Both banks are read at the same zigzag position; the drain bank picks one.
  assign out_data = out_valid ? rd_data[rd_bank] : '0;
  assign out_idx  = rd_pos;
  assign out_last = out_valid && (rd_pos == 6'd63);

  // Write and read pointers plus the per-bank full flags. A block's last write
  // and last read always target different banks, so the two flag updates
  // below never touch the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_col  <= '0;
      rd_bank <= 1'b0;
      rd_pos  <= '0;
    end else begin
      if (in_fire) begin
        // wr_col wraps from 7 back to 0 on the block's last beat
        wr_col <= wr_col + 3'd1;
        if (wr_col == 3'd7) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (out_fire) begin
        rd_pos <= rd_pos + 6'd1;
        if (rd_pos == 6'd63) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

  a_wr_bank_free: assert property (@(posedge clk) disable iff (rst)
    in_fire |-> !full[wr_bank]);

  a_no_set_clear_same_bank: assert property (@(posedge clk) disable iff (rst)
    !(in_fire && (wr_col == 3'd7) && out_fire && (rd_pos == 6'd63) && (wr_bank == rd_bank)));

`ifdef DCT_ZZ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_fire && out_last) begin
        blk_cnt <= blk_cnt + 16'd1;
      end
      if (in_valid && !in_ready) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
